// File: rtl/mem_bank_write_sequencer_if.sv
// Write-request and memory-port bundle for mem_bank_write_sequencer.
// The slave modport is the sequencer's view; master is the host/memory side.
interface mem_bank_write_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 18,
    parameter int NUM_BANKS  = 2
);
    localparam int BANK_WIDTH = $clog2(NUM_BANKS);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [BANK_WIDTH-1:0] wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  clear_req;
    logic                  busy;
    logic                  mem_reset_mem;
    logic                  mem_wea;
    logic [BANK_WIDTH-1:0] mem_banka;
    logic [ADDR_WIDTH-1:0] mem_addra;
    logic [DATA_WIDTH-1:0] mem_dia;
    logic                  mem_reset_done;
    logic [7:0]            overflow_count;

    modport slave (
        input  wr_valid, wr_bank, wr_addr, wr_data, clear_req, mem_reset_done,
        output wr_ready, busy, mem_reset_mem, mem_wea, mem_banka, mem_addra,
               mem_dia, overflow_count
    );

    modport master (
        output wr_valid, wr_bank, wr_addr, wr_data, clear_req, mem_reset_done,
        input  wr_ready, busy, mem_reset_mem, mem_wea, mem_banka, mem_addra,
               mem_dia, overflow_count
    );
endinterface

// File: rtl/mem_bank_write_sequencer.sv
// Queues host writes and sequences them, plus full-memory clears, onto a banked memory write port.
// Optional dropped-write counter: define MEM_BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN.
module mem_bank_write_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 18,
    parameter int NUM_BANKS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int BANK_WIDTH = $clog2(NUM_BANKS),
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic                     clk,
    input logic                     reset,
    mem_bank_write_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_CLEARING = 1'b1;

    typedef struct packed {
        logic [BANK_WIDTH-1:0] bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           fifo_mem [FIFO_DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [0:0]       state;

    logic wr_ready_int;
    logic push;
    logic pop;
    logic start_clear;

    assign wr_ready_int = (count != FULL_COUNT);
    assign push         = bus.wr_valid && wr_ready_int;
    assign start_clear  = (state == ST_IDLE) && bus.clear_req;
    // A clear request on the same edge wins over issuing the head entry.
    assign pop          = (state == ST_IDLE) && !bus.clear_req && (count != '0);
    assign head         = fifo_mem[rd_ptr];

    assign bus.wr_ready = wr_ready_int;
    assign bus.busy     = (state == ST_CLEARING) || bus.mem_reset_mem
                       || (count != '0) || bus.mem_wea;

    // NOTE: queue storage is deliberately not reset; pointers and count alone decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{bank: bus.wr_bank, addr: bus.wr_addr, data: bus.wr_data};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (bus.clear_req)      state <= ST_CLEARING;
                ST_CLEARING: if (bus.mem_reset_done) state <= ST_IDLE;
                default:                             state <= ST_IDLE;
            endcase
        end
    end

    // Write address/data hold their last values between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_reset_mem <= 1'b0;
            bus.mem_wea       <= 1'b0;
            bus.mem_banka     <= '0;
            bus.mem_addra     <= '0;
            bus.mem_dia       <= '0;
        end else begin
            bus.mem_reset_mem <= start_clear;
            bus.mem_wea       <= pop;
            if (pop) begin
                bus.mem_banka <= head.bank;
                bus.mem_addra <= head.addr;
                bus.mem_dia   <= head.data;
            end
        end
    end

`ifdef MEM_BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
    logic [7:0] overflow_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= 8'd0;
        end else if (bus.wr_valid && !wr_ready_int && (overflow_cnt != 8'hFF)) begin
            overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    assign bus.overflow_count = overflow_cnt;
`else
    assign bus.overflow_count = 8'd0;
`endif

endmodule

// File: doc/mem_bank_write_sequencer.md
Name: mem_bank_write_sequencer

Overview:
- Upstream feeder for the multi-bank reset-capable operator/channel state memory.
- Buffers register-derived writes (bank, addr, data) from the register-file/host decode logic in a small FIFO.
- Presents the writes on the memory's single write port, at most one per cycle.
- Sequences a full memory clear: pulses the memory's reset_mem input, and holds all queued writes until the memory reports its clear-done pulse. Every clear therefore takes effect before any write queued behind it.

Parameters:
- DATA_WIDTH, 8: width of a memory word.
- DEPTH, 18: words per bank.
- NUM_BANKS, 2: number of banks.
- FIFO_DEPTH, 4: write-queue entries. Must be a power of 2 and at least 2.
- BANK_WIDTH, $clog2(NUM_BANKS): derived; do not override.
- ADDR_WIDTH, $clog2(DEPTH): derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  queue can accept a write
- wr_bank  in  BANK_WIDTH  target bank
- wr_addr  in  ADDR_WIDTH  target address
- wr_data  in  DATA_WIDTH  write data
- clear_req  in  1  single-cycle request to clear the whole memory
- busy  out  1  clear in progress or writes pending
- mem_reset_mem  out  1  to memory reset_mem
- mem_wea  out  1  to memory wea
- mem_banka  out  BANK_WIDTH  to memory banka
- mem_addra  out  ADDR_WIDTH  to memory addra
- mem_dia  out  DATA_WIDTH  to memory dia
- mem_reset_done  in  1  from memory reset_mem_done_pulse
- overflow_count  out  8  dropped-write counter (see Optional Feature)

Behaviour:
- Reset:
  - Synchronous, active-high reset on clk.
  - Clears FIFO (pointers and count to 0) and sets state to IDLE.
  - All mem_* outputs go to 0; overflow_count goes to 0.
  - Reset during CLEARING abandons the clear and returns to IDLE. The memory shares the same reset.
- Write acceptance:
  - wr_ready = (count != FIFO_DEPTH), decoded from registered count only.
  - A write is accepted on an edge where wr_valid && wr_ready.
  - A push and a pop on the same edge leave count unchanged.
  - wr_valid while full is not accepted; the requester must hold it.
- FIFO: circular buffer. Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally at FIFO_DEPTH-1 -> 0.
- Memory outputs: all mem_* outputs are registered, and mem_wea / mem_reset_mem are single-cycle pulses.
- Issue rule, evaluated every edge:
  - If state==IDLE, clear_req==0 and FIFO not empty: mem_wea<=1, mem_banka/addra/dia<=head entry, pop.
  - Otherwise mem_wea<=0. mem_banka/addra/dia hold their last values.
- Latency: a write accepted at edge k into an empty FIFO drives mem_wea high in the cycle after edge k+1. The memory commits it at edge k+2.
- Throughput: one write per cycle while in IDLE.
- State machine:
  - IDLE:
    - clear_req=1 -> mem_reset_mem<=1 for exactly one cycle, mem_wea<=0, next CLEARING.
    - clear_req has priority over issuing a write on the same edge.
  - CLEARING:
    - No issue and no mem_reset_mem; FIFO still accepts writes.
    - clear_req is ignored (no re-trigger).
    - mem_reset_done=1 -> next IDLE; issuing resumes on the following edge.
  - mem_reset_done seen while IDLE is ignored.
- Ordering: writes queued before or during a clear are kept and issued after the clear completes, in FIFO order.
- busy = (state==CLEARING) || mem_reset_mem || (count!=0) || mem_wea.

Optional Feature:
- Macro: MEM_BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
- Defined:
  - overflow_count increments on each edge where wr_valid && !wr_ready.
  - It saturates at 255; only reset clears it.
- Undefined: overflow_count is constant 0 and no counter logic exists.

Test Plan:
- Single write into idle FIFO: wr bank=1 addr=5 data=0x3C at edge 0 -> mem_wea=1 with banka=1/addra=5/dia=0x3C during cycle after edge 1, exactly one cycle.
- Burst of 6 back-to-back writes, FIFO_DEPTH=4, wr_valid held -> wr_ready drops when count=4. All 6 are issued in order on consecutive mem_wea cycles. With the macro defined, overflow_count equals the number of cycles that wr_valid was held while wr_ready was low.
- Clear then writes:
  - Stimulus: clear_req at edge 0, 3 writes at edges 1-3, mem_reset_done driven high at edge 40.
  - Required: mem_reset_mem high one cycle, no mem_wea before edge 41, then 3 consecutive mem_wea in order, and busy=0 afterwards.
- clear_req and a pending head on the same edge -> mem_reset_mem=1, mem_wea=0, and the head entry is issued only after mem_reset_done.
- Reset asserted mid-CLEARING with 2 queued writes -> next cycle wr_ready=1, busy=0, all mem_* outputs 0, and no queued writes are issued later.
- Saturation (macro defined): hold wr_valid against a full FIFO, blocked by CLEARING, for 300 cycles -> overflow_count=255.
